spi_req_arbiter: RTL and testbench

//  Shares one byte-wide SPI master among N_REQ requesters. Round-robin arbitration; one byte per grant.

---
 rtl/spi_req_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_req_arbiter: round-robin sharing of one byte-wide SPI master      |
// | among N_REQ clients; SPI_TIMEOUT_EN adds a WAIT abort.   Rev 1.0      |
// +----------------------------------------------------------------------+
module spi_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               busy,
  output logic               timeout_err,
  output logic               spi_start_n,
  output logic [7:0]         spi_data_in,
  input  logic [7:0]         spi_data_out,
  input  logic               spi_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("spi_req_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d, spi_data_in_q, spi_data_in_d;
  logic              busy_q, busy_d, spi_start_n_q, spi_start_n_d;
  logic              done_q;
  logic              done_rise;
  logic [7:0]        req_byte [N_REQ];
  logic [IW-1:0]     pick, idx_next;
  logic              pick_vld;
  logic [IW:0]       cand;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req_byte
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Only a fresh rising edge completes a byte; a level left over from the previous byte is ignored.
  assign done_rise = spi_done & ~done_q;
  assign idx_next  = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          tmo_hit;
  assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (req[cand[IW-1:0]]) begin
        pick     = cand[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    spi_data_in_d = spi_data_in_q;
    spi_start_n_d = 1'b1;
`ifdef SPI_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          idx_d         = pick;
          spi_data_in_d = req_byte[pick];
          gnt_d         = N_REQ'(1) << pick;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        spi_start_n_d = 1'b0;
`ifdef SPI_TIMEOUT_EN
        tmo_cnt_d     = '0;
`endif
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          rsp_data_d  = spi_data_out;
          rsp_valid_d = N_REQ'(1) << idx_q;
          state_d     = S_RESP;
        end
`ifdef SPI_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_data_d    = 8'hFF;
          rsp_valid_d   = N_REQ'(1) << idx_q;
          timeout_err_d = 1'b1;
          rr_ptr_d      = idx_next;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (req_lock[idx_q] & req[idx_q]) begin
          spi_data_in_d = req_byte[idx_q];
          gnt_d         = N_REQ'(1) << idx_q;
          state_d       = S_LAUNCH;
        end else begin
          rr_ptr_d = idx_next;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      spi_data_in_q <= '0;
      spi_start_n_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      spi_data_in_q <= spi_data_in_d;
      spi_start_n_q <= spi_start_n_d;
      busy_q        <= busy_d;
      done_q        <= spi_done;
`ifdef SPI_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign spi_start_n = spi_start_n_q;
  assign spi_data_in = spi_data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_req_arbiter: directed vectors against a simple SPI master      |
// | model with loopback data.                                 Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_spi_req_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int LAT = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_lock = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [7:0]     rsp_data, spi_data_in;
  logic           busy, timeout_err, spi_start_n;
  logic [7:0]     spi_data_out = '0;
  logic           spi_done = 1'b0;

  always #5 clk = ~clk;

  spi_req_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .timeout_err(timeout_err), .spi_start_n(spi_start_n), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_done(spi_done)
  );

  typedef struct {
    logic [3:0]      rq;
    logic [31:0]     data;
    int              lidx;
    int              ln;
    int              hold;
    logic [0:5][2:0] ord;
    int              n;
  } vec_t;

  vec_t vecs [10];

  int total = 0, bad = 0, cyc = 0;
  int exp_q [$];
  int sent [N];
  int nb [N];
  bit pend = 0, prev_gnt = 0, tmo_mode = 0;
  int pend_idx = 0, done_cyc = 0, last_rsp_cyc = 0, tmo_g = 0;
  logic [7:0] pend_data = '0;
  int m_cnt = 0, m_drop = 0, m_hold = 0;
  bit m_stuck = 0;
  logic [7:0] m_buf = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic observe();
    int gi, e;
    chk("start_n", 32'(spi_start_n), prev_gnt ? 0 : 1);
    prev_gnt = |gnt;
    if (rsp_valid != 0) begin
      if (!pend) chk("rsp_unexp", 32'(rsp_valid), 0);
      else begin
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << pend_idx);
        chk("rsp_data", 32'(rsp_data), 32'(pend_data));
        if (tmo_mode) begin
          chk("tmo_lat", cyc - tmo_g, TMO + 1);
          chk("tmo_err", 32'(timeout_err), 1);
        end else begin
          chk("rsp_lat", cyc - done_cyc, 1);
          chk("tmo_err0", 32'(timeout_err), 0);
        end
        pend = 0;
        last_rsp_cyc = cyc;
      end
    end
    if (gnt != 0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
      e = gi;
      if (exp_q.size() == 0) chk("gnt_unexp", 32'(gnt), 0);
      else begin
        e = exp_q.pop_front();
        chk("gnt_idx", 32'(gnt), 32'(1) << e);
      end
      if (sent[gi] > 0) chk("lock_gap", cyc - last_rsp_cyc, 1);
      pend      = 1;
      pend_idx  = e;
      pend_data = req_data[8*gi +: 8];
      sent[gi]++;
      if (sent[gi] >= nb[gi]) begin
        req[gi]      = 1'b0;
        req_lock[gi] = 1'b0;
      end else begin
        req_data[8*gi +: 8] = req_data[8*gi +: 8] + 8'd1;
      end
    end
  endtask

  // Master: captures data on start, keeps a stale done for m_hold cycles, completes LAT cycles later.
  task automatic master();
    if (!spi_start_n) begin
      m_buf  = spi_data_in;
      m_cnt  = LAT;
      m_drop = m_hold;
      if (m_hold == 0) spi_done = 1'b0;
    end else if (m_cnt > 0) begin
      if (m_drop > 0) begin
        m_drop--;
        if (m_drop == 0) spi_done = 1'b0;
      end
      m_cnt--;
      if (m_cnt == 0 && !m_stuck) begin
        spi_done     = 1'b1;
        spi_data_out = m_buf;
        done_cyc     = cyc;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    observe();
    master();
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, "_rsp_data"}, 32'(rsp_data), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_tmo_err"}, 32'(timeout_err), 0);
    chk({nm, "_start_n"}, 32'(spi_start_n), 1);
    chk({nm, "_data_in"}, 32'(spi_data_in), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int budget;
    m_hold = v.hold;
    for (int i = 0; i < N; i++) begin
      if (v.rq[i]) begin
        nb[i]   = (i == v.lidx) ? v.ln : 1;
        sent[i] = 0;
        req_data[8*i +: 8] = v.data[8*i +: 8];
        req_lock[i] = (nb[i] > 1);
        req[i]      = 1'b1;
      end
    end
    for (int k = 0; k < v.n; k++) exp_q.push_back(int'(v.ord[k]));
    tick();
    chk({nm, "_gnt_lat"}, 32'(|gnt), 1);
    budget = 0;
    while ((exp_q.size() != 0 || pend || busy || req != 0) && budget < 300) begin
      tick();
      budget++;
    end
    chk({nm, "_drain"}, 32'(budget < 300), 1);
    m_hold = 0;
  endtask

  task automatic raise(input int i, input logic [7:0] b);
    nb[i]   = 1;
    sent[i] = 0;
    req_data[8*i +: 8] = b;
    req[i] = 1'b1;
    exp_q.push_back(i);
  endtask

  task automatic wait_gnt(input string nm, output int g);
    bit found;
    found = 0;
    g = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (gnt != 0) begin
        found = 1;
        g = cyc;
      end
    end
    chk({nm, "_gnt_seen"}, 32'(found), 1);
  endtask

  initial begin
    int g, budget;
    vec_t hv;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      nb[i]   = 1;
    end
    vecs[0] = '{rq: 4'b0001, data: 32'h000000A5, lidx: -1, ln: 1, hold: 0, ord: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    vecs[1] = '{rq: 4'b1000, data: 32'h3C000000, lidx: -1, ln: 1, hold: 0, ord: '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    vecs[2] = '{rq: 4'b1111, data: 32'h44332211, lidx: -1, ln: 1, hold: 0, ord: '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0}, n: 4};
    vecs[3] = '{rq: 4'b0001, data: 32'h00000077, lidx: -1, ln: 1, hold: 0, ord: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    vecs[4] = '{rq: 4'b0101, data: 32'h00C300C1, lidx: -1, ln: 1, hold: 0, ord: '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 2};
    vecs[5] = '{rq: 4'b1001, data: 32'hD40000D1, lidx: -1, ln: 1, hold: 0, ord: '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 2};
    vecs[6] = '{rq: 4'b0010, data: 32'h0000E200, lidx: -1, ln: 1, hold: 0, ord: '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    vecs[7] = '{rq: 4'b0110, data: 32'h00335500, lidx: 2, ln: 3, hold: 0, ord: '{3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0}, n: 4};
    vecs[8] = '{rq: 4'b1011, data: 32'h66008899, lidx: -1, ln: 1, hold: 0, ord: '{3'd3, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, n: 3};
    vecs[9] = '{rq: 4'b0010, data: 32'h00005A00, lidx: -1, ln: 1, hold: 3, ord: '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};

    repeat (3) tick();
    rst_chk("reset");
    rst = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Asynchronous reset while the master is mid-byte.
    raise(0, 8'h42);
    wait_gnt("midrst", g);
    chk("midrst_busy", 32'(busy), 1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    rst_chk("midrst");
    pend = 0;
    exp_q.delete();
    m_cnt = 0;
    spi_done = 1'b0;
    prev_gnt = 0;
    req = '0;
    req_lock = '0;
    tick();
    rst = 1'b1;
    tick();
    hv = '{rq: 4'b0010, data: 32'h00008100, lidx: -1, ln: 1, hold: 0, ord: '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    run_vec(hv, "postrst");

    // Master never completes.
    m_stuck = 1;
    raise(2, 8'h9E);
    wait_gnt("stuck", g);
`ifdef SPI_TIMEOUT_EN
    pend_data = 8'hFF;
    tmo_mode  = 1;
    tmo_g     = g;
    budget    = 0;
    while (pend && budget < 40) begin
      tick();
      budget++;
    end
    chk("tmo_seen", 32'(!pend), 1);
    tmo_mode = 0;
    chk("tmo_idle", 32'(busy), 0);
`else
    pend = 0;
    repeat (40) tick();
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_tmo", 32'(timeout_err), 0);
    rst = 1'b0;
    prev_gnt = 0;
    tick();
    rst = 1'b1;
    tick();
`endif
    m_stuck = 0;
    hv = '{rq: 4'b0001, data: 32'h0000003D, lidx: -1, ln: 1, hold: 0, ord: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, n: 1};
    run_vec(hv, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
